nco_sweep_ctrl: RTL and testbench

//  Frequency-sweep sequencer for the CORDIC NCO. Drives the NCO val/phase_inc inputs

---
 rtl/nco_sweep_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl -- frequency-sweep sequencer for the CORDIC NCO.
//
// Steps the NCO tuning word from a start word to a stop word in fixed
// increments. Each word is held for (dwell + 1) cycles. The configuration is
// captured into shadow registers when a sweep starts, so later changes to
// cfg_* have no effect on a running sweep.
//
// Optional feature: define NCO_SWEEP_PINGPONG_EN to make repeat mode sweep
// up and down between the start and stop words (triangle). Without it, repeat
// mode restarts from the start word after the stop dwell (sawtooth).
//
// Ports:
//   clk_i            clock
//   rst_n_i          asynchronous reset, active-low
//   start_i          start a sweep (acted on in IDLE only)
//   abort_i          abort the sweep from any state; wins over start_i
//   cfg_start_inc_i  first tuning word
//   cfg_stop_inc_i   last tuning word (unsigned)
//   cfg_step_i       increment per step (unsigned)
//   cfg_dwell_i      dwell per step minus 1 (0 = 1 cycle)
//   cfg_repeat_i     1 = restart at end of sweep instead of finishing
//   nco_val_o        NCO val_i
//   nco_phase_inc_o  NCO phase_inc_i; keeps the last word when idle
//   busy_o           high while a word is being dwelt on
//   done_o           one-cycle pulse at sweep completion
//   step_idx_o       current step index, 0 = start word (saturating)
module nco_sweep_ctrl #(
  parameter int P_INC_W = 16,
  parameter int DWELL_W = 16,
  parameter int IDX_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [P_INC_W-1:0] cfg_start_inc_i,
  input  logic [P_INC_W-1:0] cfg_stop_inc_i,
  input  logic [P_INC_W-1:0] cfg_step_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic               cfg_repeat_i,
  output logic               nco_val_o,
  output logic [P_INC_W-1:0] nco_phase_inc_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   step_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [P_INC_W-1:0] inc_q, inc_d;
  logic [P_INC_W-1:0] start_q, start_d;
  logic [P_INC_W-1:0] stop_q, stop_d;
  logic [P_INC_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               repeat_q, repeat_d;
  logic               val_q, val_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Upward step is computed one bit wider so it clamps at stop instead of wrapping.
  logic [P_INC_W:0]   sum_w;
  logic [P_INC_W-1:0] up_word;
  logic [IDX_W-1:0]   idx_inc;
  logic               at_stop;

  assign sum_w   = {1'b0, inc_q} + {1'b0, step_q};
  assign up_word = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[P_INC_W-1:0];
  assign idx_inc = (idx_q == '1) ? idx_q : idx_q + IDX_W'(1);
  // ">=" also covers stop < start: the first word already lies beyond stop.
  assign at_stop = (inc_q >= stop_q);

`ifdef NCO_SWEEP_PINGPONG_EN
  logic               down_q, down_d;
  logic [P_INC_W-1:0] dn_word;
  logic               at_start;

  // Downward step clamps at start; the subtraction is only taken when it
  // cannot go below start, so it never underflows.
  assign dn_word  = ((inc_q <= start_q) || (step_q >= (inc_q - start_q))) ?
                    start_q : (inc_q - step_q);
  assign at_start = (inc_q <= start_q);
`endif

  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    repeat_d = repeat_q;
    val_d    = val_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
`ifdef NCO_SWEEP_PINGPONG_EN
    down_d   = down_q;
`endif

    case (state_q)
      S_IDLE: begin
        val_d  = 1'b0;
        busy_d = 1'b0;
        if (start_i && !abort_i) begin
          start_d  = cfg_start_inc_i;
          stop_d   = cfg_stop_inc_i;
          step_d   = cfg_step_i;
          dwell_d  = cfg_dwell_i;
          repeat_d = cfg_repeat_i;
          inc_d    = cfg_start_inc_i;
          idx_d    = '0;
          cnt_d    = '0;
          val_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_DWELL;
`ifdef NCO_SWEEP_PINGPONG_EN
          down_d   = 1'b0;
`endif
        end
      end

      S_DWELL: begin
        if (abort_i) begin
          val_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
          if (down_q) begin
            if (at_start) begin
              down_d = 1'b0;
              inc_d  = up_word;
              idx_d  = '0;
            end else begin
              inc_d  = dn_word;
              idx_d  = idx_inc;
            end
          end else if (at_stop) begin
            if (repeat_q) begin
              down_d = 1'b1;
              inc_d  = dn_word;
              idx_d  = '0;
            end else begin
              val_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            inc_d = up_word;
            idx_d = idx_inc;
          end
`else
          if (at_stop) begin
            if (repeat_q) begin
              inc_d = start_q;
              idx_d = '0;
            end else begin
              val_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            inc_d = up_word;
            idx_d = idx_inc;
          end
`endif
        end
      end

      S_DONE: begin
        val_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        val_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      inc_q    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      repeat_q <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
`ifdef NCO_SWEEP_PINGPONG_EN
      down_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      repeat_q <= repeat_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
`ifdef NCO_SWEEP_PINGPONG_EN
      down_q   <= down_d;
`endif
    end
  end

  assign nco_val_o       = val_q;
  assign nco_phase_inc_o = inc_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign step_idx_o      = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, cfg_repeat;
  logic [15:0] cfg_start, cfg_stop, cfg_step, cfg_dwell;
  logic        nco_val, busy, done;
  logic [15:0] phase_inc, step_idx;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.P_INC_W(16), .DWELL_W(16), .IDX_W(16)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .cfg_start_inc_i (cfg_start),
    .cfg_stop_inc_i  (cfg_stop),
    .cfg_step_i      (cfg_step),
    .cfg_dwell_i     (cfg_dwell),
    .cfg_repeat_i    (cfg_repeat),
    .nco_val_o       (nco_val),
    .nco_phase_inc_o (phase_inc),
    .busy_o          (busy),
    .done_o          (done),
    .step_idx_o      (step_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference schedule: one entry per expected val cycle.
  int unsigned exp_w[$];
  int unsigned exp_i[$];

  task automatic build_model(input int unsigned s, e, st, d);
    int unsigned w, idx;
    exp_w.delete();
    exp_i.delete();
    w = s;
    idx = 0;
    forever begin
      for (int unsigned k = 0; k <= d; k++) begin
        exp_w.push_back(w);
        exp_i.push_back(idx);
      end
      if (w >= e) break;
      w = w + st;
      if (w > e) w = e;
      if (idx < 65535) idx++;
    end
  endtask

  task automatic run_sweep(input int unsigned s, e, st, d, input bit noisy,
                           output int unsigned nval, output int unsigned nwords,
                           output int unsigned last_w);
    int unsigned budget;
    bit seen_done;
    build_model(s, e, st, d);
    @(negedge clk);
    cfg_start = 16'(s); cfg_stop = 16'(e); cfg_step = 16'(st); cfg_dwell = 16'(d);
    cfg_repeat = 1'b0; start_i = 1'b1; abort_i = 1'b0;
    nval = 0; nwords = 0; last_w = 0; seen_done = 0;
    budget = exp_w.size() + 10;
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge clk);
      start_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) begin
        cfg_start = 16'($urandom); cfg_stop = 16'($urandom);
        cfg_step = 16'($urandom); cfg_dwell = 16'($urandom_range(0, 3));
        cfg_repeat = 1'($urandom_range(0, 1));
      end
      if (done === 1'b1) begin
        seen_done = 1;
        break;
      end
      if (c < exp_w.size()) begin
        chk("word", 32'(phase_inc), exp_w[c]);
        chk("idx", 32'(step_idx), exp_i[c]);
        chk("val", 32'(nco_val), 1);
        chk("busy", 32'(busy), 1);
      end else begin
        chk("overrun_val", 32'(nco_val), 0);
      end
      if (nco_val === 1'b1) begin
        nval++;
        if (nval == 1 || 32'(phase_inc) != last_w) nwords++;
        last_w = 32'(phase_inc);
      end
    end
    chk("done_seen", 32'(seen_done), 1);
    chk("done_val", 32'(nco_val), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_word", 32'(phase_inc), exp_w[exp_w.size()-1]);
    chk("model_len", nval, exp_w.size());
    start_i = 1'b1;  // lands on the DONE cycle, must be ignored
    @(negedge clk);
    start_i = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_val", 32'(nco_val), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  typedef struct {
    int unsigned s, e, st, d;
    int unsigned n_words, val_cycles, last;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int unsigned nval, nwords, last_w;
    int unsigned s, e, st, d, span, smin, smax;

    tbl[0] = '{s:100,   e:400,   st:100,   d:2, n_words:4, val_cycles:12, last:400};
    tbl[1] = '{s:100,   e:350,   st:100,   d:0, n_words:4, val_cycles:4,  last:350};
    tbl[2] = '{s:'hFF00, e:'hFFFF, st:'h80, d:0, n_words:3, val_cycles:3,  last:'hFFFF};
    tbl[3] = '{s:500,   e:100,   st:100,   d:0, n_words:1, val_cycles:1,  last:500};
    tbl[4] = '{s:500,   e:100,   st:100,   d:3, n_words:1, val_cycles:4,  last:500};
    tbl[5] = '{s:7,     e:7,     st:0,     d:1, n_words:1, val_cycles:2,  last:7};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cfg_repeat = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
    #1;
    chk("rst_val", 32'(nco_val), 0);
    chk("rst_word", 32'(phase_inc), 0);
    chk("rst_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_idx", 32'(step_idx), 0);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].s, tbl[i].e, tbl[i].st, tbl[i].d, (i % 2) == 1, nval, nwords, last_w);
      chk("tbl_val_cycles", nval, tbl[i].val_cycles);
      chk("tbl_n_words", nwords, tbl[i].n_words);
      chk("tbl_last", last_w, tbl[i].last);
    end

    // Abort on the second cycle of word 200, together with start.
    @(negedge clk);
    cfg_start = 100; cfg_stop = 400; cfg_step = 100; cfg_dwell = 2; cfg_repeat = 0;
    start_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("abort_pre_word", 32'(phase_inc), 200);
    abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_val", 32'(nco_val), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_word", 32'(phase_inc), 200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_idle_val", 32'(nco_val), 0);
      chk("abort_idle_done", 32'(done), 0);
    end

    // Asynchronous reset in the middle of a dwell.
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_val", 32'(nco_val), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val", 32'(nco_val), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_word", 32'(phase_inc), 0);
    chk("arst_idx", 32'(step_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_val", 32'(nco_val), 0);

    // step = 0 with start < stop holds the start word until abort.
    cfg_start = 100; cfg_stop = 200; cfg_step = 0; cfg_dwell = 0; cfg_repeat = 0;
    start_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      chk("hold_word", 32'(phase_inc), 100);
      chk("hold_val", 32'(nco_val), 1);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("hold_abort_val", 32'(nco_val), 0);
    chk("hold_abort_done", 32'(done), 0);

    // Repeat mode, start=0 stop=200 step=100 dwell=0.
    cfg_start = 0; cfg_stop = 200; cfg_step = 100; cfg_dwell = 0; cfg_repeat = 1;
    start_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      int unsigned pos;
      @(negedge clk);
      start_i = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
      pos = c % 4;
      chk("rep_word", 32'(phase_inc), (pos <= 2) ? pos * 100 : (4 - pos) * 100);
`else
      pos = c % 3;
      chk("rep_word", 32'(phase_inc), pos * 100);
      chk("rep_idx", 32'(step_idx), pos);
`endif
      chk("rep_val", 32'(nco_val), 1);
      chk("rep_done", 32'(done), 0);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("rep_abort_val", 32'(nco_val), 0);
    cfg_repeat = 0;

    // Randomized sweeps against the reference schedule.
    for (int r = 0; r < 25; r++) begin
      s = $urandom_range(0, 65535);
      if ($urandom_range(0, 4) == 0) begin
        e = $urandom_range(0, 65535);
      end else begin
        span = $urandom_range(0, 65535 - s);
        e = s + span;
      end
      span = (e > s) ? e - s : 0;
      smin = span / 20 + 1;
      smax = (smin * 4 > 65535) ? 65535 : smin * 4;
      st = $urandom_range(smin, smax);
      d = $urandom_range(0, 3);
      run_sweep(s, e, st, d, 1'b1, nval, nwords, last_w);
      chk("rnd_last", last_w, e > s ? e : s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
